// File: rtl/knn_stream_sequencer.sv
// Host-side sequencer for the KNN accelerator: frames an input word stream into
// wr/start strobes, runs the done phase, reads k results and replays them downstream.
module knn_stream_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_DIMS    = 5,
    parameter int DONE_CYCLES = 10,
    parameter int RD_LATENCY  = 2,
    parameter int MAX_K       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic [31:0]           cfg_k,
    input  logic [31:0]           cfg_num_vectors,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  knn_wr_en,
    output logic                  knn_rd_en,
    output logic                  knn_start,
    output logic                  knn_done,
    output logic [31:0]           knn_k,
    output logic [DATA_WIDTH-1:0] knn_data_out,
    input  logic [DATA_WIDTH-1:0] knn_name_in,
    input  logic [DATA_WIDTH-1:0] knn_value_in,
    output logic [DATA_WIDTH-1:0] m_name,
    output logic [DATA_WIDTH-1:0] m_value,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy
);
    localparam int PW = (MAX_K > 1) ? $clog2(MAX_K) : 1;
    localparam int CW = $clog2(MAX_K + 1);

    typedef enum logic [2:0] {IDLE, STREAM, DONE, READ, DRAIN} state_t;

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic                  start_q, start_d;
    logic                  done_q, done_d;
    logic [31:0]           k_q, k_d;
    logic [31:0]           last_vec_q, last_vec_d;
    logic [31:0]           dim_q, dim_d;
    logic [31:0]           vec_q, vec_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [31:0]           pop_cnt_q, pop_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         fcnt_q, fcnt_d;

    logic [DATA_WIDTH-1:0] name_mem [MAX_K];
    logic [DATA_WIDTH-1:0] val_mem  [MAX_K];

    logic hs, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_K - 1)) ? '0 : p + 1'b1;
    endfunction

    assign s_ready      = (state_q == STREAM);
    assign hs           = s_ready && s_valid;
    // Capture window: cycles RD_LATENCY .. RD_LATENCY+k-1 after the rd_en rise.
    assign push         = (state_q == READ) && (cnt_q >= 32'(RD_LATENCY))
                          && (cnt_q < 32'(RD_LATENCY) + k_q);
    assign m_valid      = (fcnt_q != '0);
    assign pop          = m_valid && m_ready;
    assign m_last       = m_valid && (pop_cnt_q == k_q - 32'd1);
    assign m_name       = m_valid ? name_mem[rd_ptr_q] : '0;
    assign m_value      = m_valid ? val_mem[rd_ptr_q]  : '0;
    assign knn_wr_en    = wr_en_q;
    assign knn_rd_en    = rd_en_q;
    assign knn_start    = start_q;
    assign knn_done     = done_q;
    assign knn_k        = k_q;
    assign knn_data_out = data_q;
    assign busy         = busy_q;

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        wr_en_d    = wr_en_q;
        rd_en_d    = rd_en_q;
        start_d    = hs;
        done_d     = done_q;
        k_d        = k_q;
        last_vec_d = last_vec_q;
        dim_d      = dim_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        pop_cnt_d  = pop_cnt_q;
        data_d     = hs ? s_data : data_q;
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fcnt_d     = fcnt_q;
        unique case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase
        if (pop) pop_cnt_d = pop_cnt_q + 32'd1;

        unique case (state_q)
            IDLE: begin
                if (go) begin
                    k_d        = (cfg_k > 32'(MAX_K)) ? 32'(MAX_K) : cfg_k;
                    last_vec_d = cfg_num_vectors;
                    busy_d     = 1'b1;
                    wr_en_d    = 1'b1;
                    dim_d      = '0;
                    vec_d      = '0;
                    pop_cnt_d  = '0;
                    state_d    = STREAM;
                end
            end
            STREAM: begin
                if (hs) begin
                    if (dim_q == 32'(NUM_DIMS - 1)) begin
                        dim_d = '0;
                        vec_d = vec_q + 32'd1;
                        if (vec_q == last_vec_q) begin
                            done_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = DONE;
                        end
                    end else begin
                        dim_d = dim_q + 32'd1;
                    end
                end
            end
            DONE: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == 32'(DONE_CYCLES - 1)) begin
                    done_d  = 1'b0;
                    wr_en_d = 1'b0;
                    cnt_d   = '0;
                    if (k_q != '0) begin
                        rd_en_d = 1'b1;
                        state_d = READ;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            READ: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == 32'(RD_LATENCY) + k_q - 32'd1) begin
                    rd_en_d = 1'b0;
                    state_d = DRAIN;
                end
            end
            default: ;
        endcase

        // The last push lands in the final READ cycle, so the last pop is always later.
        if (pop && m_last) begin
            busy_d  = 1'b0;
            k_d     = '0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            k_q        <= '0;
            last_vec_q <= '0;
            dim_q      <= '0;
            vec_q      <= '0;
            cnt_q      <= '0;
            pop_cnt_q  <= '0;
            data_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            start_q    <= start_d;
            done_q     <= done_d;
            k_q        <= k_d;
            last_vec_q <= last_vec_d;
            dim_q      <= dim_d;
            vec_q      <= vec_d;
            cnt_q      <= cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            data_q     <= data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fcnt_q     <= fcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            name_mem[wr_ptr_q] <= knn_name_in;
            val_mem[wr_ptr_q]  <= knn_value_in;
        end
    end
endmodule

// File: tb/tb_knn_stream_sequencer.sv
// Directed bench for knn_stream_sequencer with a small accelerator read model.
module tb_knn_stream_sequencer;
    localparam int RDL = 2;

    logic        clk = 1'b0;
    logic        reset, go, s_valid, m_ready;
    logic [31:0] cfg_k, cfg_num_vectors, s_data;
    logic        s_ready, knn_wr_en, knn_rd_en, knn_start, knn_done, m_valid, m_last, busy;
    logic [31:0] knn_k, knn_data_out, knn_name_in, knn_value_in, m_name, m_value;

    knn_stream_sequencer dut (
        .clk(clk), .reset(reset), .go(go), .cfg_k(cfg_k), .cfg_num_vectors(cfg_num_vectors),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .knn_wr_en(knn_wr_en), .knn_rd_en(knn_rd_en), .knn_start(knn_start), .knn_done(knn_done),
        .knn_k(knn_k), .knn_data_out(knn_data_out), .knn_name_in(knn_name_in),
        .knn_value_in(knn_value_in), .m_name(m_name), .m_value(m_value), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Accelerator read model: result i appears RDL+i cycles after rd_en rises.
    logic [31:0] rn [16];
    logic [31:0] rv [16];
    int          rd_cyc = 0;
    always @(posedge clk) rd_cyc <= knn_rd_en ? rd_cyc + 1 : 0;
    always_comb begin
        knn_name_in  = 32'hBAD00000 + 32'(rd_cyc);
        knn_value_in = 32'hBAD10000 + 32'(rd_cyc);
        if (knn_rd_en && rd_cyc >= RDL && rd_cyc < RDL + 16) begin
            knn_name_in  = rn[rd_cyc - RDL];
            knn_value_in = rv[rd_cyc - RDL];
        end
    end

    // Passive monitor of accelerator strobes and the result stream.
    logic        mon_clr;
    logic [31:0] cap_data [$];
    logic [64:0] res_q [$];
    int          start_cnt, done_cnt, rd_cnt, viol, run, maxrun;
    logic [31:0] prev_data;
    always @(posedge clk) begin
        if (mon_clr) begin
            cap_data.delete();
            res_q.delete();
            start_cnt <= 0; done_cnt <= 0; rd_cnt <= 0; viol <= 0; run <= 0; maxrun <= 0;
            prev_data <= knn_data_out;
        end else begin
            if (knn_start && knn_wr_en) begin
                cap_data.push_back(knn_data_out);
                start_cnt <= start_cnt + 1;
                run <= run + 1;
                if (run + 1 > maxrun) maxrun <= run + 1;
            end else begin
                run <= 0;
            end
            if (!knn_start && knn_data_out !== prev_data) viol <= viol + 1;
            prev_data <= knn_data_out;
            if (knn_done) done_cnt <= done_cnt + 1;
            if (knn_rd_en) rd_cnt <= rd_cnt + 1;
            if (m_valid && m_ready) res_q.push_back({m_last, m_name, m_value});
        end
    end

    int checks = 0;
    int errors = 0;
    int pat [30];
    int wq [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic load_words(input int nv);
        wq.delete();
        for (int i = 0; i < (nv + 1) * 5; i++) wq.push_back(pat[i]);
    endtask

    task automatic do_go(input int k, input int nv);
        cfg_k = k;
        cfg_num_vectors = nv;
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic send_words(input int n, input bit tog);
        int to;
        to = 0;
        for (int i = 0; i < n; i++) begin
            int b;
            b = 0;
            s_data  = wq[i];
            s_valid = 1'b1;
            while (!s_ready && b < 50) begin tick(); b++; end
            if (b >= 50) to++;
            tick();
            if (tog && i < n - 1) begin s_valid = 1'b0; tick(); end
        end
        s_valid = 1'b0;
        chk("stream_timeout", to, 0);
    endtask

    task automatic wait_last();
        int b;
        b = 0;
        while (!(m_valid && m_ready && m_last) && b < 500) begin tick(); b++; end
        chk("last_timeout", b < 500, 1);
        tick();
        chk("busy_drop", busy, 0);
    endtask

    task automatic chk_stream(input int n);
        chk("start_cnt", start_cnt, n);
        for (int i = 0; i < n && i < cap_data.size(); i++)
            chk($sformatf("start_data[%0d]", i), cap_data[i], wq[i]);
    endtask

    task automatic chk_results(input int n);
        chk("res_cnt", res_q.size(), n);
        for (int i = 0; i < n && i < res_q.size(); i++) begin
            logic [64:0] e;
            e = res_q[i];
            chk($sformatf("res_name[%0d]", i), e[63:32], rn[i]);
            chk($sformatf("res_value[%0d]", i), e[31:0], rv[i]);
            chk($sformatf("res_last[%0d]", i), e[64], (i == n - 1));
        end
    endtask

    task automatic chk_all_zero(input string p);
        chk({p, "_s_ready"}, s_ready, 0);
        chk({p, "_wr_en"}, knn_wr_en, 0);
        chk({p, "_rd_en"}, knn_rd_en, 0);
        chk({p, "_start"}, knn_start, 0);
        chk({p, "_done"}, knn_done, 0);
        chk({p, "_k"}, knn_k, 0);
        chk({p, "_data_out"}, knn_data_out, 0);
        chk({p, "_m_valid"}, m_valid, 0);
        chk({p, "_m_last"}, m_last, 0);
        chk({p, "_m_name"}, m_name, 0);
        chk({p, "_m_value"}, m_value, 0);
        chk({p, "_busy"}, busy, 0);
    endtask

    task automatic set_tbl1();
        for (int i = 0; i < 16; i++) begin rn[i] = 32'hEE00 + 32'(i); rv[i] = 32'hEF00 + 32'(i); end
        rn[0] = 3; rv[0] = 0;
        rn[1] = 4; rv[1] = 0;
        rn[2] = 2; rv[2] = 4;
    endtask

    initial begin
        int vecs [6][5];
        int b;
        vecs = '{'{1, 2, 2, 2, 3}, '{5, 10, 7, 9, 6}, '{1, 1, 1, 1, 1},
                 '{2, 2, 2, 2, 2}, '{2, 2, 2, 2, 2}, '{5, 5, 5, 5, 5}};
        for (int v = 0; v < 6; v++)
            for (int d = 0; d < 5; d++) pat[v * 5 + d] = vecs[v][d];
        set_tbl1();
        reset = 1'b1; go = 1'b0; s_valid = 1'b0; m_ready = 1'b1; mon_clr = 1'b0;
        cfg_k = '0; cfg_num_vectors = '0; s_data = '0;
        tick(); tick();
        chk_all_zero("reset");
        reset = 1'b0;

        // Basic job: k=3, 5 samples, back-to-back words.
        clr(); load_words(5);
        do_go(3, 5);
        chk("go_busy", busy, 1);
        chk("go_wr_en", knn_wr_en, 1);
        chk("go_k", knn_k, 3);
        chk("go_s_ready", s_ready, 1);
        cfg_k = 9; go = 1'b1; tick(); go = 1'b0;
        chk("go_ignored_k", knn_k, 3);
        send_words(30, 0);
        chk("s_ready_drop", s_ready, 0);
        chk("done_rise", knn_done, 1);
        wait_last();
        chk("k_cleared", knn_k, 0);
        chk("wr_en_end", knn_wr_en, 0);
        chk_stream(30);
        chk("start_run", maxrun, 30);
        chk("done_cycles", done_cnt, 10);
        chk("rd_cycles", rd_cnt, 5);
        chk_results(3);

        // Gapped input stream.
        clr(); load_words(5);
        do_go(3, 5);
        send_words(30, 1);
        wait_last();
        chk_stream(30);
        chk("data_hold_viol", viol, 0);
        chk_results(3);

        // Downstream stall of 20 cycles after the read phase.
        clr(); load_words(5); m_ready = 1'b0;
        do_go(3, 5);
        send_words(30, 0);
        b = 0;
        while (!knn_rd_en && b < 100) begin tick(); b++; end
        while (knn_rd_en && b < 100) begin tick(); b++; end
        chk("rd_phase_timeout", b < 100, 1);
        repeat (20) tick();
        chk("stall_m_valid", m_valid, 1);
        chk("stall_head_name", m_name, 3);
        chk("stall_no_xfer", res_q.size(), 0);
        m_ready = 1'b1;
        wait_last();
        chk_results(3);
        chk("stall_rd_cycles", rd_cnt, 5);

        // k clamp: 40 -> 16, reference only.
        for (int i = 0; i < 16; i++) begin rn[i] = 100 + i; rv[i] = 3 * i + 1; end
        clr(); load_words(0);
        do_go(40, 0);
        chk("clamp_k", knn_k, 16);
        send_words(5, 0);
        wait_last();
        chk_stream(5);
        chk_results(16);
        chk("clamp_rd_cycles", rd_cnt, 18);

        // k=0: no read phase, busy clears right after done.
        clr(); load_words(1);
        do_go(0, 1);
        chk("k0_k", knn_k, 0);
        send_words(10, 0);
        repeat (9) tick();
        chk("k0_busy_hold", busy, 1);
        chk("k0_done_hold", knn_done, 1);
        tick();
        chk("k0_busy_clr", busy, 0);
        chk("k0_done_clr", knn_done, 0);
        chk("k0_wr_en", knn_wr_en, 0);
        repeat (4) tick();
        chk("k0_no_rd", rd_cnt, 0);
        chk("k0_no_res", res_q.size(), 0);

        // Reset mid-stream, then a reference-only job.
        set_tbl1();
        clr(); load_words(5);
        do_go(3, 5);
        send_words(12, 0);
        chk("pre_reset_busy", busy, 1);
        reset = 1'b1;
        tick();
        chk_all_zero("midreset");
        reset = 1'b0;
        clr(); load_words(0);
        do_go(1, 0);
        send_words(5, 0);
        wait_last();
        chk_stream(5);
        chk_results(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/knn_stream_sequencer.md
Name: knn_stream_sequencer

Overview:
- Host-side sequencer that drives the KNN accelerator's wr_en/rd_en/start/done/k/dataValueIn interface and drains its dataNameOut/dataValueOut results.
- Accepts a reference vector followed by N sample vectors as a valid/ready word stream, frames them for the accelerator, runs the done phase, reads back the k nearest results and returns them as a valid/ready stream with a last flag.
- Sits between the AXI register/DMA front end and the accelerator core.

Parameters:
- DATA_WIDTH, 32, width of data words, names and values.
- NUM_DIMS, 5, words per vector; must be at least 1.
- DONE_CYCLES, 10, cycles knn_done is held high before the read phase; must be at least 1.
- RD_LATENCY, 2, cycles from the knn_rd_en rising edge to the first valid result.
- MAX_K, 16, result buffer depth and the clamp for k.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- go  in  1  pulse; latches cfg_k and cfg_num_vectors and starts a job
- cfg_k  in  32  number of neighbours requested
- cfg_num_vectors  in  32  number of sample vectors, excluding the reference
- s_data  in  DATA_WIDTH  input word
- s_valid  in  1  input word valid
- s_ready  out  1  sequencer accepts the word
- knn_wr_en  out  1  to accelerator wr_en
- knn_rd_en  out  1  to accelerator rd_en
- knn_start  out  1  to accelerator start; qualifies knn_data_out
- knn_done  out  1  to accelerator done
- knn_k  out  32  to accelerator k
- knn_data_out  out  DATA_WIDTH  to accelerator dataValueIn
- knn_name_in  in  DATA_WIDTH  from accelerator dataNameOut
- knn_value_in  in  DATA_WIDTH  from accelerator dataValueOut
- m_name  out  DATA_WIDTH  result name
- m_value  out  DATA_WIDTH  result value
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts the result
- m_last  out  1  marks the final result of the job
- busy  out  1  high from go until the last result has transferred

Behaviour:
- Reset: every output is 0; state IDLE; counters and result FIFO are cleared. Reset mid-job aborts the job immediately with no further accelerator strobes.
- States: IDLE -> STREAM -> DONE -> READ -> DRAIN -> IDLE.

IDLE
- On go: latch k_eff = min(cfg_k, MAX_K), drive knn_k = k_eff, latch total = cfg_num_vectors + 1 and assert busy.
- knn_wr_en goes to 1 in the cycle after go; state -> STREAM.
- go while busy is ignored.

STREAM
- s_ready = 1.
- Each s_valid && s_ready registers the word onto knn_data_out and pulses knn_start = 1 in the following cycle. Without a handshake, knn_start = 0 and knn_data_out holds.
- The accelerator samples only when knn_start && knn_wr_en; gaps are legal.
- A dimension counter wraps at NUM_DIMS-1 and increments the vector counter. Vector 0 is the reference vector.
- When vector total-1 completes: s_ready drops in that same cycle, no further word is accepted, state -> DONE.

DONE
- knn_done = 1 for exactly DONE_CYCLES cycles, then 0.
- Next cycle: knn_wr_en = 0; knn_rd_en = 1 if k_eff > 0, otherwise go straight to IDLE with busy = 0.

READ
- knn_rd_en is held for RD_LATENCY + k_eff cycles.
- Cycles RD_LATENCY through RD_LATENCY+k_eff-1 after its rise push {knn_name_in, knn_value_in} into the FIFO (depth MAX_K; overflow is impossible).
- Then knn_rd_en = 0; state -> DRAIN.

Output (READ and DRAIN)
- m_* is driven from the FIFO head in both states; m_valid = FIFO not empty.
- Pop on m_valid && m_ready; m_last = 1 on the k_eff-th result.
- A push and a pop in the same cycle are both honoured.
- After the last pop: busy = 0, knn_k = 0, state -> IDLE.

Boundary cases
- cfg_num_vectors = 0: only the reference vector is streamed.
- cfg_k > MAX_K: clamped to MAX_K.
- m_ready low is a stall only; the accelerator is never re-read.

Test Plan:
- NUM_DIMS=5, k=3, 5 samples; stream words 1,2,2,2,3 | 5,10,7,9,6 | 1×5 | 2×5 | 2×5 | 5×5 with s_valid held -> 30 knn_start pulses on consecutive cycles with data in order; knn_done high exactly 10 cycles; then knn_rd_en high 5 cycles.
- Accelerator model returns (3,0),(4,0),(2,4) from the RD_LATENCY cycle with m_ready=1 -> three results in that order, m_last only on (2,4), busy drops the cycle after.
- s_valid toggled 1,0,1,0 during STREAM -> knn_start pulses only on accepted words; knn_data_out stable while knn_start=0; final count still 30.
- m_ready held 0 for 20 cycles then 1 -> FIFO holds 3 entries, no loss or duplication, same order.
- cfg_k=40 with MAX_K=16 -> knn_k=16, exactly 16 results; cfg_k=0 -> no knn_rd_en, busy clears after the done phase.
- reset asserted mid-STREAM (after word 12) -> all outputs 0 next cycle; a new go with cfg_num_vectors=0 streams only 5 reference words.
